// File: rtl/reg_file_16x16_pkg.sv
// Shared widths, the zero-register index and the write-index decoder
// for the 16x16 architectural register file.
package reg_file_16x16_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] idx_t;

  // One-hot write enables.
  // Bit 0 is forced low so that R0 can never be written.
  function automatic logic [NUM_REGS-1:0] decode_we(input logic we, input idx_t idx);
    logic [NUM_REGS-1:0] onehot;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = we && (idx == idx_t'(i));
    end
    onehot[0] = 1'b0;
    return onehot;
  endfunction

endpackage

// File: rtl/reg_file_16x16_word.sv
// One register word of the register file.
// Synchronous active-high clear; the clear wins over a write.
module reg_word #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Register update: clear has priority, then write.
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end

endmodule

// File: rtl/reg_file_16x16.sv
// 16x16 register file: two combinational read ports, one synchronous write port.
// R0 is a constant zero.
// Optional macro RF_BYPASS_EN forwards same-cycle write data to a matching read port.
module reg_file_16x16
  import reg_file_16x16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] src_reg1,
  input  logic [ADDR_W-1:0] src_reg2,
  input  logic [ADDR_W-1:0] dst_reg,
  input  logic              write_reg,
  input  logic [DATA_W-1:0] dst_data,
  output logic [DATA_W-1:0] src_data1,
  output logic [DATA_W-1:0] src_data2,
  output logic              dbg_busy
);

  word_t               regs [NUM_REGS];
  logic [NUM_REGS-1:0] we_vec;
  logic                we_eff;

  // A write commits only outside reset and never to R0.
  assign we_eff   = write_reg && (dst_reg != ZERO_REG) && !rst;
  assign we_vec   = decode_we(write_reg, dst_reg);
  assign dbg_busy = we_eff;

  // R0 is hard-wired; it has no storage behind it.
  assign regs[0] = '0;

  genvar g;
  generate
    for (g = 1; g < NUM_REGS; g++) begin : g_word
      reg_word #(.W(DATA_W)) u_word (
        .clk (clk),
        .rst (rst),
        .we  (we_vec[g]),
        .d   (dst_data),
        .q   (regs[g])
      );
    end
  endgenerate

  // Read port 1: array mux, optional forwarding, and forced zero during reset.
  always_comb begin
    src_data1 = regs[src_reg1];
`ifdef RF_BYPASS_EN
    if (we_eff && (dst_reg == src_reg1)) src_data1 = dst_data;
`endif
    if (rst) src_data1 = '0;
  end

  // Read port 2: same structure, with forwarding decided independently of port 1.
  always_comb begin
    src_data2 = regs[src_reg2];
`ifdef RF_BYPASS_EN
    if (we_eff && (dst_reg == src_reg2)) src_data2 = dst_data;
`endif
    if (rst) src_data2 = '0;
  end

endmodule

// File: tb/tb_reg_file_16x16.sv
// Scoreboard bench for reg_file_16x16.
// The driver applies one vector per cycle and queues the expected read-port and busy values.
// The monitor pops the queue at the falling edge of the matching cycle and compares.
module tb_reg_file_16x16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src_reg1, src_reg2, dst_reg;
  logic        write_reg;
  logic [15:0] dst_data;
  logic [15:0] src_data1, src_data2;
  logic        dbg_busy;

  reg_file_16x16 dut (
    .clk       (clk),
    .rst       (rst),
    .src_reg1  (src_reg1),
    .src_reg2  (src_reg2),
    .dst_reg   (dst_reg),
    .write_reg (write_reg),
    .dst_data  (dst_data),
    .src_data1 (src_data1),
    .src_data2 (src_data2),
    .dbg_busy  (dbg_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        eb;
    bit          chk_sum;
    logic [15:0] esum;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Saturating signed nibble add, standing in for the downstream PADDSB unit.
  function automatic logic [15:0] paddsb(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    int s;
    for (int n = 0; n < 4; n++) begin
      s = int'($signed(a[n*4 +: 4])) + int'($signed(b[n*4 +: 4]));
      if (s > 7)       s = 7;
      else if (s < -8) s = -8;
      r[n*4 +: 4] = 4'(s);
    end
    return r;
  endfunction

  // Compare one field and report on mismatch.
  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and check every expectation that belongs to this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
      end else begin
        cmp({e.name, ".d1"}, src_data1, e.e1);
        cmp({e.name, ".d2"}, src_data2, e.e2);
        cmp({e.name, ".busy"}, {15'd0, dbg_busy}, {15'd0, e.eb});
        if (e.chk_sum) cmp({e.name, ".paddsb"}, paddsb(src_data1, src_data2), e.esum);
      end
    end
  end

  // Apply one cycle of stimulus, shortly after the rising edge.
  task automatic drive(input logic r, input logic we, input logic [3:0] d,
                       input logic [15:0] data, input logic [3:0] s1, input logic [3:0] s2);
    @(posedge clk);
    #1;
    rst = r; write_reg = we; dst_reg = d; dst_data = data;
    src_reg1 = s1; src_reg2 = s2;
  endtask

  task automatic expect_out(input string name, input logic [15:0] e1, input logic [15:0] e2,
                            input logic eb);
    exp_t e;
    e.cyc = cyc; e.name = name; e.e1 = e1; e.e2 = e2; e.eb = eb;
    e.chk_sum = 1'b0; e.esum = '0;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; write_reg = 1'b0; dst_reg = '0; dst_data = '0;
    src_reg1 = '0; src_reg2 = '0;

    // Reset state
    drive(1, 0, 0, 16'h0, 4'd4, 4'd9);           expect_out("rst_hold", 16'h0, 16'h0, 0);
    drive(0, 0, 0, 16'h0, 4'd4, 4'd15);          expect_out("post_rst", 16'h0, 16'h0, 0);

    // T1: preload R1..R15 with FFFF, then reset, then every index reads 0
    for (int i = 1; i < 16; i++) begin
      drive(0, 1, 4'(i), 16'hFFFF, 4'd0, 4'd0);  expect_out("t1_load", 16'h0, 16'h0, 1);
    end
    drive(0, 0, 0, 16'h0, 4'd15, 4'd1);          expect_out("t1_full", 16'hFFFF, 16'hFFFF, 0);
    drive(1, 0, 0, 16'h0, 4'd6, 4'd12);          expect_out("t1_in_rst", 16'h0, 16'h0, 0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 16'h0, 4'(i), 4'(15 - i));  expect_out("t1_clear", 16'h0, 16'h0, 0);
    end

    // T2: write then read on both ports next cycle
    drive(0, 1, 4'd3, 16'h7A5C, 4'd0, 4'd0);     expect_out("t2_wr", 16'h0, 16'h0, 1);
    drive(0, 0, 0, 16'h0, 4'd3, 4'd3);           expect_out("t2_rd", 16'h7A5C, 16'h7A5C, 0);

    // T3: writes to R0 are discarded and never bypassed
    drive(0, 1, 4'd0, 16'hBEEF, 4'd0, 4'd3);     expect_out("t3_wr0", 16'h0, 16'h7A5C, 0);
    drive(0, 0, 0, 16'h0, 4'd0, 4'd0);           expect_out("t3_rd0", 16'h0, 16'h0, 0);

    // T4: same-cycle hazard on port 1, port 2 on an unrelated register
    drive(0, 1, 4'd5, 16'h1111, 4'd0, 4'd0);     expect_out("t4_pre", 16'h0, 16'h0, 1);
    drive(0, 1, 4'd5, 16'h2222, 4'd5, 4'd3);
    expect_out("t4_same", BYP ? 16'h2222 : 16'h1111, 16'h7A5C, 1);
    drive(0, 0, 0, 16'h0, 4'd5, 4'd5);           expect_out("t4_next", 16'h2222, 16'h2222, 0);

    // Both ports hitting a register being written in the same cycle; R15 is the top index
    drive(0, 1, 4'd15, 16'hABCD, 4'd15, 4'd15);
    expect_out("byp_both", BYP ? 16'hABCD : 16'h0, BYP ? 16'hABCD : 16'h0, 1);
    drive(0, 1, 4'd15, 16'hABCD, 4'd15, 4'd3);   expect_out("hold_we", 16'hABCD, 16'h7A5C, 1);
    drive(0, 0, 0, 16'h0, 4'd15, 4'd3);          expect_out("r15_rd", 16'hABCD, 16'h7A5C, 0);

    // T5: reset wins over a same-edge write, and no bypass during reset
    drive(1, 1, 4'd7, 16'h0F0F, 4'd7, 4'd15);    expect_out("t5_rstwr", 16'h0, 16'h0, 0);
    drive(0, 0, 0, 16'h0, 4'd7, 4'd15);          expect_out("t5_after", 16'h0, 16'h0, 0);

    // T6: operands for the saturating nibble adder
    drive(0, 1, 4'd1, 16'h7777, 4'd0, 4'd0);     expect_out("t6_w1", 16'h0, 16'h0, 1);
    drive(0, 1, 4'd2, 16'h1111, 4'd0, 4'd0);     expect_out("t6_w2", 16'h0, 16'h0, 1);
    drive(0, 0, 0, 16'h0, 4'd1, 4'd2);
    begin
      exp_t e;
      e.cyc = cyc; e.name = "t6_paddsb"; e.e1 = 16'h7777; e.e2 = 16'h1111; e.eb = 1'b0;
      e.chk_sum = 1'b1; e.esum = 16'h7777;
      exp_q.push_back(e);
    end

    // Drain the scoreboard with a bounded wait
    drive(0, 0, 0, 16'h0, 4'd0, 4'd0);
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      errors += exp_q.size();
      checks += exp_q.size();
      $display("FAIL drain: %0d expectations never checked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
